// File: rtl/gate_truth_checker.sv
// Walks a 2-input gate through all four input pairs, waits SETTLE_CYCLES per pair,
// and compares each sampled output against a captured 4-bit expected truth table.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    // state  | meaning
    // IDLE   | waiting for start; gate inputs held at 00
    // SETTLE | current vector applied, counting settle cycles
    // SAMPLE | compare dut_out with expected[idx], advance or finish
    // FINISH | one-cycle done pulse, results published
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] exp_q, exp_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] in_q, in_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_q, fail_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        in_d    = in_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                    mask_d  = 4'd0;
                    in_d    = 2'b00;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                // Case-inequality so an undriven or X gate output counts as a mismatch.
                if (dut_out !== exp_q[idx_q]) mask_d[idx_q] = 1'b1;
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    in_d    = idx_q + 2'd1;
                    cnt_d   = 8'd0;
                    state_d = ST_SETTLE;
                end else begin
                    in_d    = 2'b00;
                    done_d  = 1'b1;
                    fail_d  = mask_d;
                    pass_d  = (mask_d == 4'd0);
                    state_d = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            exp_q   <= 4'd0;
            mask_q  <= 4'd0;
            in_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            in_q    <= in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign in1       = in_q[1];
    assign in2       = in_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Drives gate_truth_checker against behavioural gate models and checks
// vector sequencing, timing, results and reset/start corner cases.
module tb_gate_truth_checker;

    localparam int S      = 2;
    localparam int VEC    = S + 1;
    localparam int DONE_K = 4 * VEC;
    localparam int PERIOD = 4 * VEC + 2;

    localparam int M_NOR = 0, M_AND = 1, M_XOR = 2, M_ST0 = 3, M_ST1 = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] expected;
    logic       dut_out;
    logic       in1, in2, busy, done, pass;
    logic [3:0] fail_mask;
    int         gate_mode;

    gate_truth_checker #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .dut_out(dut_out), .in1(in1), .in2(in2), .busy(busy),
        .done(done), .pass(pass), .fail_mask(fail_mask)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (gate_mode)
            M_NOR:   dut_out = ~(in1 | in2);
            M_AND:   dut_out = in1 & in2;
            M_XOR:   dut_out = in1 ^ in2;
            M_ST0:   dut_out = 1'b0;
            default: dut_out = 1'b1;
        endcase
    end

    typedef struct {
        logic [3:0] exp;
        int         mode;
        logic       pass;
        logic [3:0] mask;
    } vec_t;

    vec_t       tbl[7];
    logic [4:0] sb_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    logic       prev_pass = 1'b0;
    logic [3:0] prev_mask = 4'd0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and score any done pulse.
    task automatic cycle();
        logic [4:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("pass", int'(pass), int'(e[4]));
                chk("fail_mask", int'(fail_mask), int'(e[3:0]));
                prev_pass = e[4];
                prev_mask = e[3:0];
            end
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_in"}, int'({in1, in2}), 0);
    endtask

    // Full run: accept, then follow every cycle until done.
    task automatic run_vec(input logic [3:0] exp, input int mode, input logic p, input logic [3:0] m);
        int k;
        gate_mode = mode;
        expected  = exp;
        start     = 1'b1;
        sb_q.push_back({p, m});
        cycle();
        start = 1'b0;
        chk("accept_busy", int'(busy), 1);
        chk("accept_in", int'({in1, in2}), 0);
        k = 0;
        while (k < DONE_K + 8) begin
            cycle();
            k++;
            if (done === 1'b1) break;
            chk("run_in", int'({in1, in2}), (k < DONE_K) ? k / VEC : 0);
            chk("run_hold", int'({pass, fail_mask}), int'({prev_pass, prev_mask}));
        end
        chk("done_edge", k, DONE_K);
        chk("finish_in", int'({in1, in2}), 0);
        chk("finish_busy", int'(busy), 1);
        cycle();
        check_idle("post_done");
        chk("post_hold", int'({pass, fail_mask}), int'({p, m}));
    endtask

    initial begin
        int k;
        int d0;
        int dcyc[3];
        int nd;

        tbl[0] = '{4'b0001, M_NOR, 1'b1, 4'b0000};
        tbl[1] = '{4'b0001, M_ST0, 1'b0, 4'b0001};
        tbl[2] = '{4'b1000, M_NOR, 1'b0, 4'b1001};
        tbl[3] = '{4'b0110, M_XOR, 1'b1, 4'b0000};
        tbl[4] = '{4'b0001, M_ST1, 1'b0, 4'b1110};
        tbl[5] = '{4'b1000, M_AND, 1'b1, 4'b0000};
        tbl[6] = '{4'b0111, M_NOR, 1'b0, 4'b0110};

        rst = 1'b1; start = 1'b0; expected = 4'd0; gate_mode = M_NOR;
        cycle();
        cycle();
        rst = 1'b0;
        check_idle("reset");
        chk("reset_pass", int'(pass), 0);
        chk("reset_mask", int'(fail_mask), 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i].exp, tbl[i].mode, tbl[i].pass, tbl[i].mask);
        end

        // expected change and start re-pulse mid-run are both ignored
        gate_mode = M_NOR; expected = 4'b0001; start = 1'b1;
        sb_q.push_back({1'b1, 4'b0000});
        cycle();
        start = 1'b0;
        d0 = done_cnt;
        for (k = 1; k <= 4; k++) cycle();
        expected = 4'b1111; start = 1'b1;
        cycle();
        start = 1'b0;
        k = 5;
        while (k < DONE_K + 8 && done !== 1'b1) begin
            cycle();
            k++;
        end
        chk("midrun_done_edge", k, DONE_K);
        for (int j = 0; j < 20; j++) cycle();
        chk("midrun_done_count", done_cnt - d0, 1);
        chk("midrun_idle_busy", int'(busy), 0);

        // reset during SETTLE of vector 2, with start also high on the reset edge
        gate_mode = M_XOR; expected = 4'b0110; start = 1'b1;
        sb_q.push_back({1'b1, 4'b0000});
        cycle();
        start = 1'b0;
        for (k = 1; k <= 2 * VEC + 1; k++) cycle();
        chk("pre_reset_in", int'({in1, in2}), 2);
        rst = 1'b1; start = 1'b1;
        cycle();
        rst = 1'b0; start = 1'b0;
        check_idle("mid_reset");
        chk("mid_reset_results", int'({pass, fail_mask}), 0);
        sb_q.delete();
        prev_pass = 1'b0; prev_mask = 4'd0;
        d0 = done_cnt;
        for (int j = 0; j < DONE_K + 4; j++) cycle();
        chk("reset_no_done", done_cnt - d0, 0);
        run_vec(4'b0001, M_NOR, 1'b1, 4'b0000);

        // start held high: back-to-back runs
        gate_mode = M_NOR; expected = 4'b0001; start = 1'b1;
        repeat (3) sb_q.push_back({1'b1, 4'b0000});
        nd = 0;
        d0 = done_cnt;
        k = 0;
        while (nd < 3 && k < 4 * PERIOD) begin
            cycle();
            k++;
            if (done_cnt != d0) begin
                dcyc[nd] = last_done_cyc;
                nd++;
                d0 = done_cnt;
            end
            if (nd > 0) chk("held_pass", int'(pass), 1);
        end
        start = 1'b0;
        chk("held_done_count", nd, 3);
        if (nd == 3) begin
            chk("held_period_1", dcyc[1] - dcyc[0], PERIOD);
            chk("held_period_2", dcyc[2] - dcyc[1], PERIOD);
        end
        for (int j = 0; j < PERIOD + 4; j++) cycle();
        chk("held_stop_busy", int'(busy), 0);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: number of settle cycles per input vector before sampling; legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a truth-table check; accepted only in IDLE.
REQ-005 SHALL have port expected, input, 4 bits: expected gate output; bit {in1,in2} is the output for that input pair (NOR = 4'b0001, AND = 4'b1000).
REQ-006 SHALL have port dut_out, input, 1 bit: output of the 2-input gate under test.
REQ-007 SHALL have port in1, output, 1 bit: first gate input driven to the DUT.
REQ-008 SHALL have port in2, output, 1 bit: second gate input driven to the DUT.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking a completed check.
REQ-011 SHALL have port pass, output, 1 bit: high when the last completed check had no mismatches.
REQ-012 SHALL have port fail_mask, output, 4 bits: bit i set when vector i ({in1,in2}=i) mismatched.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SAMPLE, FINISH; all outputs registered.
REQ-014 IDLE with start=1 at an edge SHALL capture expected into an internal register, clear vector index idx (2 bits), settle counter cnt and the working mismatch mask, drive {in1,in2}=2'b00, and enter SETTLE.
REQ-015 SETTLE SHALL increment cnt each cycle and enter SAMPLE at the edge where cnt==SETTLE_CYCLES-1.
REQ-016 SAMPLE SHALL compare dut_out with captured expected[idx]; any value other than the expected 0/1 (including X/Z in simulation) SHALL set working mask bit idx.
REQ-017 SAMPLE with idx<3 SHALL increment idx, drive {in1,in2}=idx+1, clear cnt, and return to SETTLE.
REQ-018 SAMPLE with idx==3 SHALL enter FINISH.
REQ-019 FINISH SHALL assert done for exactly one cycle, load fail_mask with the final working mask, set pass=(mask==4'b0000), and return to IDLE.
REQ-020 Each vector SHALL occupy SETTLE_CYCLES+1 cycles; done SHALL be high in the cycle following edge 4*(SETTLE_CYCLES+1) after the accepting edge (edge 12 for the default).
REQ-021 pass and fail_mask SHALL hold their values until the next FINISH; they SHALL NOT change during a run.
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and FINISH; no queueing.
REQ-023 Changes to expected after the accepting edge SHALL NOT affect the running check.
REQ-024 in1/in2 SHALL be 0 in IDLE and FINISH and SHALL change only on the SAMPLE-to-SETTLE transition or on start acceptance.
REQ-025 With start held high continuously, runs SHALL repeat back to back with period 4*(SETTLE_CYCLES+1)+2 cycles.

Reset
REQ-026 rst=1 at an edge SHALL, from any state, force IDLE, in1=0, in2=0, busy=0, done=0, pass=0, fail_mask=0, idx=0, cnt=0, and clear the working mask; start is ignored in that cycle.
REQ-027 A run interrupted by reset SHALL produce no done pulse; the next accepted start SHALL run a fresh check.

Verification
REQ-028 Correct NOR DUT, expected=4'b0001, start pulse -> {in1,in2} steps 00,01,10,11 for 3 cycles each; done at edge 12; pass=1, fail_mask=0000.
REQ-029 dut_out stuck at 0, expected=4'b0001 -> done at edge 12; pass=0, fail_mask=0001.
REQ-030 NOR DUT, expected=4'b1000 (AND) -> pass=0, fail_mask=1001.
REQ-031 expected changed to 4'b1111 and start re-pulsed mid-run -> both ignored; single done; results from the original expected.
REQ-032 rst asserted in SETTLE of vector 2 -> all outputs 0 the next cycle and no done pulse; a following start gives a full 12-cycle run.
REQ-033 start held high, NOR DUT -> done pulses every 14 cycles; pass stays 1 throughout.
